// File: rtl/imm_ext_pipe_pkg.sv
// rtl/imm_ext_pipe_pkg.sv - extender mode encodings shared by the ID->EX immediate pipe and the controller
package imm_ext_pipe_pkg;

   localparam int EXT_OP_W = 3;

   localparam logic [EXT_OP_W-1:0] EXT_ZERO = 3'b000;
   localparam logic [EXT_OP_W-1:0] EXT_SIGN = 3'b001;
   localparam logic [EXT_OP_W-1:0] EXT_LUI  = 3'b010;
   localparam logic [EXT_OP_W-1:0] EXT_BR   = 3'b011;
   localparam logic [EXT_OP_W-1:0] EXT_JMP  = 3'b100;

endpackage

// File: rtl/imm_ext_core.sv
// rtl/imm_ext_core.sv - stateless mode decode and immediate extension; branch add is left to the caller
module imm_ext_core
   import imm_ext_pipe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int IMM_W  = 16
) (
   input  logic [DATA_W-1:0]   instr,
   input  logic [DATA_W-1:0]   pc,
   input  logic [EXT_OP_W-1:0] ext_op,
   output logic [DATA_W-1:0]   ext_val,
   output logic [DATA_W-1:0]   pc4
);

   logic [IMM_W-1:0]  imm;
   logic [DATA_W-1:0] sext;
   logic              unused_opcode;

   assign imm  = instr[IMM_W-1:0];
   assign sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
   assign pc4  = pc + DATA_W'(4);

   // opcode field is not part of any result
   assign unused_opcode = ^instr[DATA_W-1:DATA_W-6];

   // mode select; for BR only the scaled offset is produced so the add can be placed per pipe depth
   always_comb begin
      ext_val = '0;
      case (ext_op)
         EXT_ZERO: ext_val = {{(DATA_W-IMM_W){1'b0}}, imm};
         EXT_SIGN: ext_val = sext;
         EXT_LUI:  ext_val = {imm, {(DATA_W-IMM_W){1'b0}}};
         EXT_BR:   ext_val = {sext[DATA_W-3:0], 2'b00};
         EXT_JMP:  ext_val = {pc4[DATA_W-1:DATA_W-4], instr[DATA_W-7:0], 2'b00};
         default:  ext_val = '0;
      endcase
   end

endmodule

// File: rtl/imm_ext_pipe.sv
// rtl/imm_ext_pipe.sv - pipelined immediate/target generator with valid/ready slots, flush and occupancy
module imm_ext_pipe
   import imm_ext_pipe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int IMM_W  = 16,
   parameter int STAGES = 2
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DATA_W-1:0]          instr,
   input  logic [DATA_W-1:0]          pc,
   input  logic [2:0]                 ext_op,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_W-1:0]          out_imm,
   output logic [DATA_W-1:0]          out_pc,
   output logic [2:0]                 out_op,
   output logic [$clog2(STAGES+1)-1:0] occupancy
);

   localparam int OCC_W = $clog2(STAGES+1);

   logic [STAGES-1:0]             valid_q;
   logic [STAGES-1:0]             adv;
   logic [STAGES-1:0]             load;
   logic [STAGES-1:0][DATA_W-1:0] val_q;
   logic [STAGES-1:0][DATA_W-1:0] pc_q;
   logic [STAGES-1:0][2:0]        op_q;
   logic [STAGES-1:0][DATA_W-1:0] val_in;
   logic [STAGES-1:0][DATA_W-1:0] pc_in;
   logic [STAGES-1:0][2:0]        op_in;
   logic [OCC_W-1:0]              occ_q;
   logic [DATA_W-1:0]             core_val;
   logic [DATA_W-1:0]             core_pc4;
   logic                          accept;
   logic                          drain;

   imm_ext_core #(
      .DATA_W (DATA_W),
      .IMM_W  (IMM_W)
   ) u_core (
      .instr   (instr),
      .pc      (pc),
      .ext_op  (ext_op),
      .ext_val (core_val),
      .pc4     (core_pc4)
   );

   // advance chain, resolved from the output slot back towards the input
   always_comb begin
      adv = '0;
      adv[STAGES-1] = valid_q[STAGES-1] & out_ready;
      for (int k = STAGES-2; k >= 0; k--) begin
         adv[k] = valid_q[k] & (~valid_q[k+1] | adv[k+1]);
      end
   end

   assign in_ready = ~valid_q[0] | adv[0];
   assign accept   = in_valid & in_ready & ~flush;
   assign drain    = adv[STAGES-1];

   // per-slot load enables and upstream pc/op; flush blocks every load so data regs hold
   always_comb begin
      load     = '0;
      pc_in    = '0;
      op_in    = '0;
      load[0]  = accept;
      pc_in[0] = pc;
      op_in[0] = ext_op;
      for (int k = 1; k < STAGES; k++) begin
         load[k]  = adv[k-1] & ~flush;
         pc_in[k] = pc_q[k-1];
         op_in[k] = op_q[k-1];
      end
   end

   generate
      if (STAGES == 1) begin : g_single
         assign val_in[0] = (ext_op == EXT_BR) ? core_val + core_pc4 : core_val;
      end else begin : g_split
         logic [DATA_W-1:0] pc4_q;

         // pc+4 rides with slot 0 so the branch add sits between slot 0 and slot 1
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               pc4_q <= '0;
            end else if (load[0]) begin
               pc4_q <= core_pc4;
            end
         end

         assign val_in[0] = core_val;
         assign val_in[1] = (op_q[0] == EXT_BR) ? val_q[0] + pc4_q : val_q[0];
         for (genvar k = 2; k < STAGES; k++) begin : g_copy
            assign val_in[k] = val_q[k-1];
         end
      end
   endgenerate

   // slot array: load when upstream advances, clear when advancing with no reload, flush empties all
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= '0;
         val_q   <= '0;
         pc_q    <= '0;
         op_q    <= '0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (flush) begin
               valid_q[k] <= 1'b0;
            end else begin
               valid_q[k] <= load[k] | (valid_q[k] & ~adv[k]);
            end
            if (load[k]) begin
               val_q[k] <= val_in[k];
               pc_q[k]  <= pc_in[k];
               op_q[k]  <= op_in[k];
            end
         end
      end
   end

   // occupancy: +1 on accept, -1 on drain, flush drops everything including the output entry
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         occ_q <= '0;
      end else if (flush) begin
         occ_q <= '0;
      end else if (accept && !drain) begin
         occ_q <= occ_q + OCC_W'(1);
      end else if (!accept && drain) begin
         occ_q <= occ_q - OCC_W'(1);
      end
   end

   assign out_valid = valid_q[STAGES-1];
   assign out_imm   = val_q[STAGES-1];
   assign out_pc    = pc_q[STAGES-1];
   assign out_op    = op_q[STAGES-1];
   assign occupancy = occ_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb/tb_imm_ext_pipe.sv - directed checks of imm_ext_pipe built with STAGES 1, 2 and 4
module tb_imm_ext_pipe;
   import imm_ext_pipe_pkg::*;

   localparam int NI = 3;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic [NI-1:0]        flush;
   logic [NI-1:0]        in_valid;
   logic [NI-1:0]        out_ready;
   logic [NI-1:0]        in_ready;
   logic [NI-1:0]        out_valid;
   logic [NI-1:0][31:0]  instr;
   logic [NI-1:0][31:0]  pc;
   logic [NI-1:0][31:0]  out_imm;
   logic [NI-1:0][31:0]  out_pc;
   logic [NI-1:0][2:0]   ext_op;
   logic [NI-1:0][2:0]   out_op;
   logic [NI-1:0][2:0]   occ;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int S = (g == 0) ? 1 : (g == 1) ? 2 : 4;
      logic [$clog2(S+1)-1:0] occ_raw;
      imm_ext_pipe #(
         .DATA_W (32),
         .IMM_W  (16),
         .STAGES (S)
      ) u_dut (
         .clk       (clk),
         .reset_n   (reset_n),
         .flush     (flush[g]),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .instr     (instr[g]),
         .pc        (pc[g]),
         .ext_op    (ext_op[g]),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .out_imm   (out_imm[g]),
         .out_pc    (out_pc[g]),
         .out_op    (out_op[g]),
         .occupancy (occ_raw)
      );
      assign occ[g] = 3'(occ_raw);
   end

   typedef struct {
      logic [2:0]  op;
      logic [31:0] ins;
      logic [31:0] pcv;
      logic [31:0] exp;
   } vec_t;

   vec_t vt [13];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic run_vec(input int s, input int lat, input vec_t v, input int idx);
      int cyc;
      out_ready[s] = 1'b1;
      in_valid[s]  = 1'b1;
      instr[s]     = v.ins;
      pc[s]        = v.pcv;
      ext_op[s]    = v.op;
      #1;
      chk($sformatf("s%0d_v%0d_in_ready", s, idx), 32'(in_ready[s]), 32'd1);
      step();
      in_valid[s] = 1'b0;
      cyc = 1;
      while (!out_valid[s] && cyc < 12) begin
         step();
         cyc++;
      end
      chk($sformatf("s%0d_v%0d_latency", s, idx), 32'(cyc), 32'(lat));
      chk($sformatf("s%0d_v%0d_imm", s, idx), out_imm[s], v.exp);
      chk($sformatf("s%0d_v%0d_op", s, idx), 32'(out_op[s]), 32'(v.op));
      chk($sformatf("s%0d_v%0d_pc", s, idx), out_pc[s], v.pcv);
      step();
      chk($sformatf("s%0d_v%0d_drained", s, idx), 32'(out_valid[s]), 32'd0);
   endtask

   task automatic run_stream(input int s, input int st);
      int sent, got, first, last;
      logic [31:0] held;
      bit have_held;
      sent = 0; got = 0; first = -1; last = -1; have_held = 0; held = '0;
      ext_op[s] = EXT_ZERO;
      for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
         out_ready[s] = (cyc >= 6);
         in_valid[s]  = (sent < 6);
         instr[s]     = 32'hABCD_0000 | 32'(sent + 1);
         pc[s]        = 32'(sent * 4);
         #1;
         if (cyc == 5) begin
            chk($sformatf("s%0d_stall_accepts", s), 32'(sent), 32'(st));
            chk($sformatf("s%0d_stall_in_ready", s), 32'(in_ready[s]), 32'd0);
            chk($sformatf("s%0d_stall_occ", s), 32'(occ[s]), 32'(st));
         end
         if (cyc == 6) chk($sformatf("s%0d_full_drain_in_ready", s), 32'(in_ready[s]), 32'd1);
         if (cyc == 7) chk($sformatf("s%0d_full_drain_occ", s), 32'(occ[s]), 32'(st));
         if (out_valid[s] && !out_ready[s]) begin
            if (have_held) chk($sformatf("s%0d_stall_stable", s), out_imm[s], held);
            held = out_imm[s];
            have_held = 1;
         end
         if (out_valid[s] && out_ready[s]) begin
            chk($sformatf("s%0d_stream_imm%0d", s, got), out_imm[s], 32'(got + 1));
            chk($sformatf("s%0d_stream_pc%0d", s, got), out_pc[s], 32'(got * 4));
            if (first < 0) first = cyc;
            last = cyc;
            got++;
         end
         if (in_valid[s] && in_ready[s]) sent++;
         step();
      end
      in_valid[s] = 1'b0;
      chk($sformatf("s%0d_stream_count", s), 32'(got), 32'd6);
      chk($sformatf("s%0d_stream_rate", s), 32'(last - first), 32'd5);
      chk($sformatf("s%0d_stream_empty_occ", s), 32'(occ[s]), 32'd0);
   endtask

   task automatic run_flush(input int s, input int st);
      int seen;
      out_ready[s] = 1'b0;
      ext_op[s] = EXT_ZERO;
      for (int i = 0; i < st; i++) begin
         in_valid[s] = 1'b1;
         instr[s] = 32'h100 + 32'(i);
         #1;
         chk($sformatf("s%0d_fill_in_ready%0d", s, i), 32'(in_ready[s]), 32'd1);
         step();
      end
      in_valid[s] = 1'b1;
      instr[s] = 32'h0000_DEAD;
      flush[s] = 1'b1;
      out_ready[s] = 1'b1;
      #1;
      chk($sformatf("s%0d_flush_pre_occ", s), 32'(occ[s]), 32'(st));
      step();
      flush[s] = 1'b0;
      in_valid[s] = 1'b0;
      chk($sformatf("s%0d_flush_out_valid", s), 32'(out_valid[s]), 32'd0);
      chk($sformatf("s%0d_flush_occ", s), 32'(occ[s]), 32'd0);
      seen = 0;
      for (int i = 0; i < st + 3; i++) begin
         step();
         if (out_valid[s]) seen++;
      end
      chk($sformatf("s%0d_flush_ghost", s), 32'(seen), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int st;
      flush = '0; in_valid = '0; out_ready = '1; instr = '0; pc = '0; ext_op = '0;

      vt[0]  = '{EXT_ZERO, 32'h1000_FFFC, 32'h0040_0010, 32'h0000_FFFC};
      vt[1]  = '{EXT_SIGN, 32'h1000_FFFC, 32'h0040_0010, 32'hFFFF_FFFC};
      vt[2]  = '{EXT_LUI,  32'h1000_FFFC, 32'h0040_0010, 32'hFFFC_0000};
      vt[3]  = '{EXT_BR,   32'h1000_FFFC, 32'h0040_0010, 32'h0040_0004};
      vt[4]  = '{EXT_JMP,  32'h1000_FFFC, 32'h0040_0010, 32'h0003_FFF0};
      vt[5]  = '{3'b111,   32'h1000_FFFC, 32'h0040_0010, 32'h0000_0000};
      vt[6]  = '{3'b101,   32'h1234_5678, 32'h0000_0000, 32'h0000_0000};
      vt[7]  = '{EXT_BR,   32'h0000_0001, 32'hFFFF_FFF8, 32'h0000_0000};
      vt[8]  = '{EXT_JMP,  32'h0000_0001, 32'hAFFF_FFFC, 32'hB000_0004};
      vt[9]  = '{EXT_SIGN, 32'hABCD_7FFF, 32'h0000_0100, 32'h0000_7FFF};
      vt[10] = '{EXT_BR,   32'h0000_0010, 32'h0000_1000, 32'h0000_1044};
      vt[11] = '{3'b110,   32'hFFFF_FFFF, 32'h0000_0200, 32'h0000_0000};
      vt[12] = '{EXT_LUI,  32'h0000_1234, 32'h0000_0300, 32'h1234_0000};

      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      for (int s = 0; s < NI; s++) begin
         chk($sformatf("s%0d_rst_out_valid", s), 32'(out_valid[s]), 32'd0);
         chk($sformatf("s%0d_rst_occ", s), 32'(occ[s]), 32'd0);
         chk($sformatf("s%0d_rst_imm", s), out_imm[s], 32'd0);
      end
      reset_n = 1'b1;
      #1;
      for (int s = 0; s < NI; s++) chk($sformatf("s%0d_rst_in_ready", s), 32'(in_ready[s]), 32'd1);
      step();

      for (int s = 0; s < NI; s++) begin
         st = (s == 0) ? 1 : (s == 1) ? 2 : 4;
         for (int v = 0; v < 13; v++) run_vec(s, st, vt[v], v);
         run_stream(s, st);
         run_flush(s, st);
         run_vec(s, st, vt[3], 99);
      end

      for (int s = 0; s < NI; s++) begin
         in_valid[s] = 1'b1;
         out_ready[s] = 1'b0;
         instr[s] = 32'h5555_5555;
         pc[s] = 32'h0000_0444;
         ext_op[s] = EXT_SIGN;
      end
      step();
      step();
      in_valid = '0;
      chk("midrst_pre_occ_s2", 32'(occ[1]), 32'd2);
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      for (int s = 0; s < NI; s++) begin
         chk($sformatf("s%0d_midrst_out_valid", s), 32'(out_valid[s]), 32'd0);
         chk($sformatf("s%0d_midrst_occ", s), 32'(occ[s]), 32'd0);
         chk($sformatf("s%0d_midrst_imm", s), out_imm[s], 32'd0);
         chk($sformatf("s%0d_midrst_pc", s), out_pc[s], 32'd0);
         chk($sformatf("s%0d_midrst_op", s), 32'(out_op[s]), 32'd0);
      end
      @(negedge clk);
      reset_n = 1'b1;
      out_ready = '1;
      #1;
      for (int s = 0; s < NI; s++) chk($sformatf("s%0d_midrst_in_ready", s), 32'(in_ready[s]), 32'd1);
      step();
      for (int s = 0; s < NI; s++) chk($sformatf("s%0d_midrst_dropped", s), 32'(out_valid[s]), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
